// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one 32-bit ALU among NREQ requesters, with a registered response bus.
// Optional macro ALU_OPCHECK_EN adds rsp_error and squashes unsupported ALUCtrl codes.
module alu_share_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [4*NREQ-1:0]    req_op,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [31:0]          rsp_result,
  output logic                 rsp_zero,
  output logic                 rsp_overflow,
`ifdef ALU_OPCHECK_EN
  output logic                 rsp_error,
`endif
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] op_id;
  logic [3:0]      op_reg;
  logic [31:0]     a_reg;
  logic [31:0]     b_reg;

  logic [3:0]      op_arr [NREQ];
  logic [31:0]     a_arr  [NREQ];
  logic [31:0]     b_arr  [NREQ];

  logic            grant_any;
  logic [ID_W-1:0] grant_id;
  logic [ID_W-1:0] ptr_next;
  logic [ID_W:0]   cand;

  logic [31:0]     sum;
  logic [31:0]     diff;
  logic            add_ovf;
  logic            sub_ovf;
  logic [31:0]     alu_result;
  logic            alu_zero;
  logic            alu_ovf;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign op_arr[gi] = req_op[4*gi +: 4];
      assign a_arr[gi]  = req_a[32*gi +: 32];
      assign b_arr[gi]  = req_b[32*gi +: 32];
    end
  endgenerate

  // Search starts at rr_ptr and wraps, so the most recently served requester goes last.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NREQ)) cand = cand - (ID_W+1)'(NREQ);
      if (!grant_any && req_valid[cand[ID_W-1:0]]) begin
        grant_any = 1'b1;
        grant_id  = cand[ID_W-1:0];
      end
    end
  end

  assign ptr_next = (grant_id == ID_W'(NREQ - 1)) ? '0 : grant_id + 1'b1;

  always_comb begin
    req_ready = '0;
    if (state == IDLE && grant_any && !reset) req_ready[grant_id] = 1'b1;
  end

  assign busy = (state != IDLE);

  // The ALU sees only the latched operands, so requesters may change their buses after transfer.
  always_comb begin
    sum        = a_reg + b_reg;
    diff       = a_reg - b_reg;
    add_ovf    = (a_reg[31] == b_reg[31]) && (sum[31] != a_reg[31]);
    sub_ovf    = (a_reg[31] != b_reg[31]) && (diff[31] != a_reg[31]);
    alu_result = '0;
    alu_ovf    = 1'b0;
    case (op_reg)
      4'd0:  alu_result = a_reg & b_reg;
      4'd1:  alu_result = a_reg | b_reg;
      4'd2:  begin alu_result = sum;  alu_ovf = add_ovf; end
      4'd6:  begin alu_result = diff; alu_ovf = sub_ovf; end
      4'd7:  begin alu_result = {31'b0, diff[31] ^ sub_ovf}; alu_ovf = sub_ovf; end
      4'd12: alu_result = ~(a_reg | b_reg);
      4'd13: alu_result = ~(a_reg & b_reg);
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

`ifdef ALU_OPCHECK_EN
  logic op_legal;
  always_comb begin
    case (op_reg)
      4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd13: op_legal = 1'b1;
      default:                                    op_legal = 1'b0;
    endcase
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      op_id        <= '0;
      op_reg       <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_overflow <= 1'b0;
`ifdef ALU_OPCHECK_EN
      rsp_error    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            op_reg <= op_arr[grant_id];
            a_reg  <= a_arr[grant_id];
            b_reg  <= b_arr[grant_id];
            op_id  <= grant_id;
            rr_ptr <= ptr_next;
            state  <= EXEC;
          end
        end
        EXEC: begin
          rsp_valid <= 1'b1;
          rsp_id    <= op_id;
`ifdef ALU_OPCHECK_EN
          rsp_error    <= !op_legal;
          rsp_result   <= op_legal ? alu_result : 32'h0;
          rsp_zero     <= op_legal ? alu_zero : 1'b1;
          rsp_overflow <= op_legal ? alu_ovf : 1'b0;
`else
          rsp_result   <= alu_result;
          rsp_zero     <= alu_zero;
          rsp_overflow <= alu_ovf;
`endif
          state <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
